// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the mem_copy block-copy engine.
package mem_copy_pkg;

  localparam int COUNT_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LATCH,
    WR,
    FIN
  } state_t;

  // Idle/reset levels of the memory-port outputs.
  localparam logic        MEM_REQ_RST     = 1'b0;
  localparam logic        MEM_WRB_RST     = 1'b1;
  localparam int unsigned MEM_ADDRESS_RST = 0;
  localparam int unsigned MEM_WDATA_RST   = 0;

endpackage

// File: rtl/mem_copy.sv
// Block-copy engine on the shared single-port SPRAM (one-cycle read latency).
// Optional block fill is enabled by defining MEM_COPY_FILL_EN.
module mem_copy
  import mem_copy_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    START,
  input  logic [ADDRESS_BITS-1:0] SRC_ADDR,
  input  logic [ADDRESS_BITS-1:0] DST_ADDR,
  input  logic [COUNT_BITS-1:0]   COUNT,
`ifdef MEM_COPY_FILL_EN
  input  logic                    FILL,
  input  logic [BITS-1:0]         FILL_VALUE,
`endif
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    MEM_REQ,
  input  logic                    MEM_GNT,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  output logic [BITS-1:0]         MEM_WDATA,
  input  logic [BITS-1:0]         MEM_RDATA,
  output logic                    MEM_WRb
);

  state_t                  state, next_state;
  logic [ADDRESS_BITS-1:0] src, dst;
  logic [COUNT_BITS-1:0]   remaining;
  logic [BITS-1:0]         data;
  logic                    fill_start, fill_mode;

`ifdef MEM_COPY_FILL_EN
  assign fill_start = FILL;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      fill_mode <= 1'b0;
    end else if (state == IDLE && START) begin
      fill_mode <= FILL;
    end
  end
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
`endif

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (START) begin
          if (COUNT == '0)     next_state = FIN;
          else if (fill_start) next_state = WR;
          else                 next_state = RD;
        end
      end
      RD:    if (MEM_GNT) next_state = LATCH;
      LATCH: next_state = WR;
      WR: begin
        if (MEM_GNT) begin
          if (remaining == COUNT_BITS'(1)) next_state = FIN;
          else if (fill_mode)              next_state = WR;
          else                             next_state = RD;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the data register is a single word, not a memory array, so it is
  // reset; MEM_WDATA is observed directly and must come out of reset at 0.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!RSTb) begin
      state     <= IDLE;
      src       <= ADDRESS_BITS'(MEM_ADDRESS_RST);
      dst       <= ADDRESS_BITS'(MEM_ADDRESS_RST);
      remaining <= '0;
      data      <= BITS'(MEM_WDATA_RST);
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (START && COUNT != '0) begin
            src       <= SRC_ADDR;
            dst       <= DST_ADDR;
            remaining <= COUNT;
`ifdef MEM_COPY_FILL_EN
            if (FILL) data <= FILL_VALUE;
`endif
          end
        end
        // The read was issued in RD; its data is on the bus now regardless of grant.
        LATCH: begin
          data <= MEM_RDATA;
          src  <= src + 1'b1;
        end
        WR: begin
          if (MEM_GNT) begin
            dst       <= dst + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Only MEM_WRb looks at MEM_GNT combinationally; everything else is registered.
  assign BUSY        = (state != IDLE);
  assign DONE        = (state == FIN);
  assign MEM_REQ     = BUSY ? 1'b1 : MEM_REQ_RST;
  assign MEM_ADDRESS = (state == WR) ? dst : src;
  assign MEM_WDATA   = data;
  assign MEM_WRb     = (state == WR) ? ~MEM_GNT : MEM_WRB_RST;

endmodule

// File: tb/tb_mem_copy.sv
// Self-checking bench for mem_copy: SPRAM model, array-level copy reference,
// directed cases plus randomized copies (fill cases when MEM_COPY_FILL_EN).
module tb_mem_copy;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        START = 1'b0;
  logic [15:0] SRC_ADDR = '0, DST_ADDR = '0, COUNT = '0;
`ifdef MEM_COPY_FILL_EN
  logic        FILL = 1'b0;
  logic [15:0] FILL_VALUE = '0;
`endif
  logic        BUSY, DONE, MEM_REQ, MEM_WRb;
  logic        MEM_GNT = 1'b0;
  logic [15:0] MEM_ADDRESS, MEM_WDATA, MEM_RDATA;

  always #5 CLK = ~CLK;

  mem_copy #(.BITS(16), .ADDRESS_BITS(16)) dut (
    .CLK(CLK), .RSTb(RSTb), .START(START),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .COUNT(COUNT),
`ifdef MEM_COPY_FILL_EN
    .FILL(FILL), .FILL_VALUE(FILL_VALUE),
`endif
    .BUSY(BUSY), .DONE(DONE), .MEM_REQ(MEM_REQ), .MEM_GNT(MEM_GNT),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_WRb(MEM_WRb)
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] wlog [$];
  int n_cmp = 0;
  int n_bad = 0;

  // SPRAM: one-cycle read latency; when the port is lent elsewhere the bus carries junk.
  always @(posedge CLK) begin
    if (MEM_GNT) begin
      if (!MEM_WRb) begin
        mem[MEM_ADDRESS] <= MEM_WDATA;
        wlog.push_back(MEM_ADDRESS);
      end
      MEM_RDATA <= mem[MEM_ADDRESS];
    end else begin
      MEM_RDATA <= 16'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: word-by-word ascending copy (or fill) on a plain array.
  task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input int m,
                            input bit fill, input logic [15:0] fv);
    logic [15:0] s, d;
    s = src;
    d = dst;
    for (int i = 0; i < m; i++) begin
      ref_mem[d] = fill ? fv : ref_mem[s];
      s = s + 16'd1;
      d = d + 16'd1;
    end
  endtask

  task automatic check_image(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) bad++;
    check(tag, bad, 0);
  endtask

  function automatic logic gnt_for(input int mode, input int k);
    case (mode)
      1:       return ($urandom_range(9, 0) < 7);
      2:       return !(k >= 3 && k <= 7);
      default: return 1'b1;
    endcase
  endfunction

  // Cycle 0 carries START; cycle k is k clocks later. Outputs sampled at negedge.
  task automatic run_copy(input string name, input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] cnt, input int gmode, input int rst_at,
                          input int words, input bit fill, input logic [15:0] fv);
    int done_k, lows, busy_n, viol, exp_k, limit, bad;
    logic [15:0] a;
    done_k = -1; lows = 0; busy_n = 0; viol = 0; bad = 0;
    limit  = 40 * int'(cnt) + 60;
    if (gmode == 1)    exp_k = -1;
    else if (cnt == 0) exp_k = 1;
    else if (fill)     exp_k = int'(cnt) + 1;
    else               exp_k = 3 * int'(cnt) + 1;
    if (gmode == 2) exp_k += 5;
    wlog.delete();

    START = 1'b1; SRC_ADDR = src; DST_ADDR = dst; COUNT = cnt;
`ifdef MEM_COPY_FILL_EN
    FILL = fill; FILL_VALUE = fv;
`endif
    MEM_GNT = gnt_for(gmode, 0);
    @(negedge CLK);
    for (int k = 1; k <= limit; k++) begin
      @(posedge CLK); #1;
      START   = 1'b0;
      MEM_GNT = gnt_for(gmode, k);
      if (rst_at >= 0 && k == rst_at)     RSTb = 1'b0;
      if (rst_at >= 0 && k == rst_at + 2) RSTb = 1'b1;
      @(negedge CLK);
      if (!MEM_WRb) lows++;
      if (!MEM_WRb && !MEM_GNT) viol++;
      if (MEM_REQ !== BUSY) viol++;
      if (BUSY) busy_n++;
      if (rst_at >= 0 && k == rst_at + 1) begin
        check({name, "/rst_busy"}, BUSY, 1'b0);
        check({name, "/rst_done"}, DONE, 1'b0);
        check({name, "/rst_req"},  MEM_REQ, 1'b0);
        check({name, "/rst_wrb"},  MEM_WRb, 1'b1);
        check({name, "/rst_addr"}, MEM_ADDRESS, 16'h0000);
        check({name, "/rst_wdata"}, MEM_WDATA, 16'h0000);
      end
      if (DONE === 1'b1) begin done_k = k; break; end
      if (rst_at >= 0 && k == rst_at + 6) break;
    end

    if (rst_at < 0) begin
      check({name, "/done_seen"}, done_k >= 0, 1'b1);
      if (exp_k >= 0) begin
        check({name, "/done_cycle"}, done_k, exp_k);
        check({name, "/busy_cycles"}, busy_n, exp_k);
      end
    end else begin
      check({name, "/no_done"}, done_k, 32'hFFFF_FFFF);
    end
    check({name, "/write_strobes"}, lows, words);
    check({name, "/gnt_req_rules"}, viol, 0);

    @(posedge CLK); #1;
    MEM_GNT = 1'b1;
    @(negedge CLK);
    check({name, "/done_pulse"}, {BUSY, DONE}, 2'b00);
    @(posedge CLK); #1;

    model_copy(src, dst, words, fill, fv);
    check_image({name, "/mem_image"});
    check({name, "/write_count"}, wlog.size(), words);
    for (int i = 0; i < wlog.size() && i < words; i++) begin
      a = dst + 16'(i);
      if (wlog[i] !== a) bad++;
    end
    check({name, "/write_order"}, bad, 0);
  endtask

  initial begin
    logic [15:0] s, d, c;
    int gm;
    bit  f;
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16'h0100 + i]     = 16'hA001 + 16'(i);
      ref_mem[16'h0100 + i] = 16'hA001 + 16'(i);
    end
    mem[16'hFFFF] = 16'h1111; ref_mem[16'hFFFF] = 16'h1111;
    mem[16'h0000] = 16'h2222; ref_mem[16'h0000] = 16'h2222;

    RSTb = 1'b0;
    MEM_GNT = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset/busy",  BUSY, 1'b0);
    check("reset/done",  DONE, 1'b0);
    check("reset/req",   MEM_REQ, 1'b0);
    check("reset/wrb",   MEM_WRb, 1'b1);
    check("reset/addr",  MEM_ADDRESS, 16'h0000);
    check("reset/wdata", MEM_WDATA, 16'h0000);
    @(posedge CLK); #1;
    RSTb = 1'b1;
    @(posedge CLK); #1;

    run_copy("basic", 16'h0100, 16'h4100, 16'd4, 0, -1, 4, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++)
      check("basic/dest_word", mem[16'h4100 + i], 16'hA001 + 16'(i));
    run_copy("count0", 16'h1234, 16'h5678, 16'd0, 0, -1, 0, 1'b0, 16'h0);
    run_copy("withhold", 16'h0900, 16'h0A00, 16'd2, 2, -1, 2, 1'b0, 16'h0);
    run_copy("wrap", 16'hFFFF, 16'h7FFF, 16'd2, 0, -1, 2, 1'b0, 16'h0);
    check("wrap/word0", mem[16'h7FFF], 16'h1111);
    check("wrap/word1", mem[16'h8000], 16'h2222);
    run_copy("reset_mid", 16'h3000, 16'h6000, 16'd8, 0, 8, 2, 1'b0, 16'h0);
    run_copy("after_rst", 16'h3100, 16'h6100, 16'd1, 0, -1, 1, 1'b0, 16'h0);
`ifdef MEM_COPY_FILL_EN
    run_copy("fill", 16'h0000, 16'h2000, 16'd3, 0, -1, 3, 1'b1, 16'h5A5A);
`endif

    for (int t = 0; t < 8; t++) begin
      s  = 16'($urandom);
      d  = (t == 0) ? s + 16'd1 : 16'($urandom);
      c  = 16'($urandom_range(12, 1));
      gm = t % 2;
      f  = 1'b0;
`ifdef MEM_COPY_FILL_EN
      f  = bit'($urandom_range(1, 0));
`endif
      run_copy($sformatf("rand%0d", t), s, d, c, gm, -1, int'(c), f, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_copy.md
# mem_copy

Block-copy engine acting as an initiator on the single-port SPRAM memory interface (ADDRESS / DATA_IN / DATA_OUT / WRb, one-cycle read latency). It shares the memory port with the CPU through a request/grant pair. Once started, it reads a run of words from a source address and writes them to a destination address, then pulses DONE. It sits beside the CPU in the iCE40 top level, ahead of the memory port multiplexer.

## Interface
- BITS, 16, data word width
- ADDRESS_BITS, 16, memory address width; addresses wrap modulo 2^ADDRESS_BITS
- CLK  in  1  system clock; all logic is on the rising edge
- RSTb  in  1  reset, synchronous, active-low
- START  in  1  one-cycle request; sampled only in IDLE
- SRC_ADDR  in  ADDRESS_BITS  first source word address, latched on START
- DST_ADDR  in  ADDRESS_BITS  first destination word address, latched on START
- COUNT  in  16  number of words to copy, latched on START; 0 is legal
- BUSY  out  1  high from the cycle after START until DONE
- DONE  out  1  one-cycle completion pulse
- MEM_REQ  out  1  memory port request; high whenever BUSY
- MEM_GNT  in  1  port granted to this block this cycle
- MEM_ADDRESS  out  ADDRESS_BITS  to memory ADDRESS
- MEM_WDATA  out  BITS  to memory DATA_IN
- MEM_RDATA  in  BITS  from memory DATA_OUT
- MEM_WRb  out  1  active-low write strobe; asserted only while MEM_GNT is high

## Operation
- States: IDLE, RD, LATCH, WR, FIN.
- IDLE:
  - START with COUNT≠0: latch src, dst and remaining=COUNT, then go to RD.
  - START with COUNT=0: go to FIN.
- RD: drive MEM_ADDRESS=src and MEM_WRb=1.
  - If MEM_GNT=1, go to LATCH.
  - Otherwise hold in RD.
- LATCH: capture MEM_RDATA into the data register unconditionally, because the read already occurred. Increment src and go to WR.
- WR: drive MEM_ADDRESS=dst, MEM_WDATA=the data register, and MEM_WRb=!MEM_GNT.
  - If MEM_GNT=1: increment dst and decrement remaining. If remaining becomes 0, go to FIN; otherwise go to RD.
  - If MEM_GNT=0: hold in WR, with the write not yet performed.
- FIN: DONE=1 for one cycle, then go to IDLE.
- src and dst increment modulo 2^ADDRESS_BITS. remaining is 16-bit unsigned.
- START while not in IDLE is ignored. Inputs are not re-sampled.
- Overlapping source and destination regions are copied in ascending address order with no overlap correction.

## Timing
- Reset values: BUSY=0, DONE=0, MEM_REQ=0, MEM_WRb=1, MEM_ADDRESS=0, MEM_WDATA=0, state=IDLE.
- RSTb low during any state aborts the copy on the next edge. The abort produces no DONE, and no further writes occur.
- With MEM_GNT held high, each word takes 3 cycles (RD, LATCH, WR).
- N words with continuous grant: DONE asserts 3N+1 cycles after the START edge. COUNT=0: DONE asserts 1 cycle after the START edge.
- MEM_WRb, MEM_ADDRESS and MEM_WDATA are driven from registered state. The only combinational dependency on MEM_GNT is the gating of MEM_WRb.
- Grant withdrawal in LATCH has no effect; the captured data stays valid.

## Configuration
- MEM_COPY_FILL_EN defined:
  - Adds input FILL (1 bit) and input FILL_VALUE (BITS wide), both latched on START.
  - With FILL=1, the engine skips RD and LATCH: IDLE goes directly to WR, and the data register is loaded with FILL_VALUE. SRC_ADDR is ignored.
  - Fill runs at 1 word per granted cycle. DONE asserts N+1 cycles after START with continuous grant.
- MEM_COPY_FILL_EN undefined: the FILL and FILL_VALUE ports are absent, and the engine behaves as copy-only.

## Structure
- Shared package mem_copy_pkg contains:
  - The state enum (IDLE, RD, LATCH, WR, FIN).
  - The COUNT width constant (16).
  - The reset constants for the memory-port outputs.
- Single module; no sub-module is natural. The address counters and the word counter are simple registers inside the FSM block.

## Test plan
- Copy with grant tied high: SRC=0x0100, DST=0x4100, COUNT=4, source data 0xA001..0xA004 -> destination 0x4100..0x4103 holds 0xA001..0xA004, DONE at cycle 13 after START, exactly 4 MEM_WRb lows.
- COUNT=0 -> DONE one cycle after START, BUSY high for exactly 1 cycle, no memory accesses.
- Grant toggling: MEM_GNT low for 5 cycles during the first WR of COUNT=2 -> MEM_WRb stays high throughout the withheld cycles, final data is correct, DONE is delayed by 5 cycles.
- Wrap-around: SRC=0xFFFF, DST=0x7FFF, COUNT=2 -> reads from 0xFFFF then 0x0000, writes to 0x7FFF then 0x8000.
- Reset mid-copy: RSTb low during word 3 of COUNT=8 -> all outputs return to reset values on the next edge, no DONE, words 3..8 are unwritten. A following START with COUNT=1 completes normally.
- MEM_COPY_FILL_EN: FILL=1, FILL_VALUE=0x5A5A, DST=0x2000, COUNT=3 -> 0x2000..0x2002 hold 0x5A5A, no read cycles, DONE 4 cycles after START.
